// File: rtl/fault_mem_cfg.sv
// rtl/fault_mem_cfg.sv - runtime-configurable faulty single-port memory model (option macro: FAULT_MEM_ARRAY_RST_EN)
module fault_mem_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64,
    parameter int BIT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_read,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  flt_load,
    input  logic [2:0]            flt_mode,
    input  logic [ADDR_WIDTH-1:0] flt_victim,
    input  logic [ADDR_WIDTH-1:0] flt_aggr,
    input  logic [BIT_W-1:0]      flt_bit,
    output logic                  flt_hit,
    output logic [7:0]            flt_hit_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        M_NONE  = 3'd0,
        M_SA0   = 3'd1,
        M_SA1   = 3'd2,
        M_TFU   = 3'd3,
        M_TFD   = 3'd4,
        M_CFIN  = 3'd5,
        M_CFID  = 3'd6,
        M_NONE7 = 3'd7
    } mode_e;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // fault configuration
    mode_e                 mode_q;
    logic [ADDR_WIDTH-1:0] vic_q;
    logic [ADDR_WIDTH-1:0] aggr_q;
    logic [BIT_W-1:0]      bit_q;

    // write pipeline: one registered write waiting to commit
    logic                  wr_pend_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    // read pipeline: captured (already fault-adjusted) word, then rdata
    logic                  rd_vld_q;
    logic [DATA_WIDTH-1:0] rd_word_q;
    logic                  rd_hit_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  hit_q;
    logic [7:0]            cnt_q;

    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      vic_idx;
    logic                  commit_en;
    logic [DATA_WIDTH-1:0] old_w;
    logic [DATA_WIDTH-1:0] commit_word;
    logic                  tf_hit;
    logic                  cf_en;
    logic [DATA_WIDTH-1:0] vic_old;
    logic [DATA_WIDTH-1:0] vic_new;
    logic                  cf_hit;
    logic                  rd_in;
    logic [DATA_WIDTH-1:0] rd_raw;
    logic [DATA_WIDTH-1:0] rd_word_d;
    logic                  rd_hit_d;
    logic                  hit_d;

    // commit-time fault rules: transition faults on the victim, coupling from the aggressor
    always_comb begin
        wr_idx      = wr_addr_q[IDX_W-1:0];
        vic_idx     = vic_q[IDX_W-1:0];
        commit_en   = wr_pend_q && in_range(wr_addr_q) && !rst;
        old_w       = mem_q[wr_idx];
        commit_word = wr_data_q;
        tf_hit      = 1'b0;
        if (commit_en && (wr_addr_q == vic_q)) begin
            if ((mode_q == M_TFU) && !old_w[bit_q] && wr_data_q[bit_q]) begin
                commit_word[bit_q] = 1'b0;
                tf_hit             = 1'b1;
            end
            if ((mode_q == M_TFD) && old_w[bit_q] && !wr_data_q[bit_q]) begin
                commit_word[bit_q] = 1'b1;
                tf_hit             = 1'b1;
            end
        end
        cf_en   = commit_en && ((mode_q == M_CFIN) || (mode_q == M_CFID)) &&
                  (wr_addr_q == aggr_q) && (aggr_q != vic_q) && in_range(vic_q) &&
                  !old_w[bit_q] && wr_data_q[bit_q];
        vic_old = mem_q[vic_idx];
        vic_new = vic_old;
        cf_hit  = 1'b0;
        if (cf_en) begin
            if (mode_q == M_CFIN) begin
                vic_new[bit_q] = ~vic_old[bit_q];
                cf_hit         = 1'b1;
            end else begin
                vic_new[bit_q] = 1'b1;
                cf_hit         = ~vic_old[bit_q];
            end
        end
    end

    // read-capture path: out-of-range reads give 0, stuck-at forces the victim bit
    always_comb begin
        rd_in     = in_range(address);
        rd_raw    = mem_q[address[IDX_W-1:0]];
        rd_word_d = rd_in ? rd_raw : '0;
        rd_hit_d  = 1'b0;
        if (rd_in && (address == vic_q) && ((mode_q == M_SA0) || (mode_q == M_SA1))) begin
            rd_word_d[bit_q] = (mode_q == M_SA1);
            rd_hit_d         = rd_raw[bit_q] != (mode_q == M_SA1);
        end
        hit_d = tf_hit || cf_hit || (rd_vld_q && rd_hit_q);
    end

    // array update: aggressor/target commit plus optional coupled victim write
    always_ff @(posedge clk) begin
`ifdef FAULT_MEM_ARRAY_RST_EN
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (commit_en) begin
                mem_q[wr_idx] <= commit_word;
            end
            if (cf_en) begin
                mem_q[vic_idx] <= vic_new;
            end
        end
`else
        if (commit_en) begin
            mem_q[wr_idx] <= commit_word;
        end
        if (cf_en) begin
            mem_q[vic_idx] <= vic_new;
        end
`endif
    end

    // pipeline, configuration and hit-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= M_NONE;
            vic_q     <= '0;
            aggr_q    <= '0;
            bit_q     <= '0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_word_q <= '0;
            rd_hit_q  <= 1'b0;
            rdata_q   <= '0;
            hit_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (flt_load) begin
                mode_q <= mode_e'(flt_mode);
                vic_q  <= flt_victim;
                aggr_q <= flt_aggr;
                bit_q  <= flt_bit;
            end
            wr_pend_q <= write_read;
            wr_addr_q <= address;
            wr_data_q <= wdata;
            rd_vld_q  <= !write_read;
            if (!write_read) begin
                rd_word_q <= rd_word_d;
                rd_hit_q  <= rd_hit_d;
            end
            if (rd_vld_q) begin
                rdata_q <= rd_word_q;
            end
            hit_q <= hit_d;
            if (hit_d && (cnt_q != 8'hFF)) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign rdata       = rdata_q;
    assign flt_hit     = hit_q;
    assign flt_hit_cnt = cnt_q;

endmodule

// File: doc/fault_mem_cfg.md
# fault_mem_cfg

Parametrised, runtime-configurable faulty single-port memory model used as the device-under-test behind the MBIST controller. Functionally a synchronous RAM with the established write-data pipeline and two-stage registered read, plus one injectable fault per configuration: stuck-at, transition or coupling, on any victim word/bit and any aggressor word. It replaces per-run regenerated fault memories: one netlist covers a full fault campaign, and a hit counter confirms each injected fault was exercised.

## Interface
- DATA_WIDTH, 8, word width (>= 2)
- ADDR_WIDTH, 6, address width
- DEPTH, 64, number of words (<= 2**ADDR_WIDTH)
- BIT_W, $clog2(DATA_WIDTH), width of the bit-select field (derived)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- write_read  in  1  1 = write, 0 = read
- address  in  ADDR_WIDTH  word address
- wdata  in  DATA_WIDTH  write data
- rdata  out  DATA_WIDTH  registered read data
- flt_load  in  1  pulse: capture fault configuration
- flt_mode  in  3  0 none, 1 SA0, 2 SA1, 3 TF-up, 4 TF-down, 5 CFin, 6 CFid1, 7 none
- flt_victim  in  ADDR_WIDTH  victim word
- flt_aggr  in  ADDR_WIDTH  aggressor word (CF modes only)
- flt_bit  in  BIT_W  victim/aggressor bit index
- flt_hit  out  1  one-cycle pulse when the fault altered a stored or read value
- flt_hit_cnt  out  8  saturating count of flt_hit pulses

## Operation
- Write at edge t: write_read, address and wdata are registered. Commit to the array happens at edge t+1. The fault rule is evaluated against array contents at commit time.
- Read at edge t: array word is captured into an internal stage at t and into rdata at t+1. rdata holds until the next read completes.
- No write-to-read bypass. A read sampled on the same edge as a commit to the same address returns the pre-commit word.
- address >= DEPTH: writes are dropped, reads return 0, and no fault is evaluated.
- Config registers load on any edge with flt_load=1. A commit on that same edge uses the old config. Modes 0 and 7 are fault-free.
- SA0/SA1: on reads of flt_victim, bit flt_bit of the read result is forced to 0/1. Stored data is untouched. A hit is flagged when the forced bit differs from the stored bit.
- TF-up/TF-down: on commit to flt_victim, if the stored bit is 0 and the new bit is 1 (TF-up), or 1 and 0 (TF-down), the bit keeps its old value. Other bits are written normally. This counts as a hit.
- CFin: on commit to flt_aggr where the aggressor bit flt_bit goes 0->1, the aggressor is written normally and victim bit flt_bit is inverted on the same edge. This counts as a hit.
- CFid1: same trigger as CFin; the victim bit is set to 1. It is a hit only if the bit was 0.
- flt_aggr == flt_victim in CF modes: no coupling effect, plain write.
- flt_hit_cnt increments per flt_hit and saturates at 255.

## Timing
- Reset values: rdata=0, flt_hit=0, flt_hit_cnt=0, config mode=0, victim/aggr/bit=0. All pipeline registers are cleared and a pending write is discarded.
- Reset mid-operation: a write registered before rst never commits. An in-flight read yields rdata=0.
- Read latency: 2 edges from the address sample to valid rdata. Back-to-back reads give one word per cycle.
- Write commit latency: 1 edge after sampling. Back-to-back writes are fully pipelined.
- flt_hit asserts in the cycle after the commit or read-capture edge that caused it, aligned with rdata for reads.
- rst dominates flt_load and write_read.

## Configuration
- FAULT_MEM_ARRAY_RST_EN defined: rst also clears every array word to 0.
- FAULT_MEM_ARRAY_RST_EN undefined: array contents are untouched by reset (X in simulation until written). Only the registers listed under Timing are reset.

## Test plan
- Mode 0, DEPTH 64: write 0x55 to address 10, then read 10 -> rdata=0x55 two edges after the read sample. flt_hit_cnt stays 0.
- SA1, victim 5, bit 3: write 0x00 to 5, then read 5 -> rdata=0x08 and flt_hit pulses. Load mode 0 and read again -> rdata=0x00.
- TF-up, victim 7, bit 1: write 0x00 then 0xFF to 7, then read -> rdata=0xFD and flt_hit_cnt=1.
- CFin, aggr 20, victim 21, bit 1: victim=0x00, write 0x02 to 20 -> victim reads 0x02. Write 0x02 to 20 again -> no change (no 0->1 edge).
- flt_load coincident with a write to victim: the write commits fault-free. Assert rst during a pending write -> no commit, and rdata=0 and flt_hit_cnt=0 after reset.
- Write to address 70 with ADDR_WIDTH 7 and DEPTH 64 -> dropped. Reading 70 returns 0. Under FAULT_MEM_ARRAY_RST_EN, every word reads 0 after reset.
